// File: rtl/npc_pkg.sv
// npc_pkg: shared operand-select, ALU op and micro-op payload definitions
package npc_pkg;
  localparam int XLEN_D = 64;
  localparam int RW_D = 5;
  function automatic int uop_w(int xlen, int rw);
    return 2 * xlen + 4 + rw + 1;
  endfunction
  localparam int UOP_W = uop_w(XLEN_D, RW_D);
  typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} skid_state_t;
  localparam logic [1:0] ASEL_RS1 = 2'd0;
  localparam logic [1:0] ASEL_PC = 2'd1;
  localparam logic [1:0] ASEL_ZERO = 2'd2;
  localparam logic [1:0] BSEL_RS2 = 2'd0;
  localparam logic [1:0] BSEL_IMM = 2'd1;
  localparam logic [1:0] BSEL_FOUR = 2'd2;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_MUL = 4'd2;
  localparam logic [3:0] ALU_DIV = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR = 4'd5;
  localparam logic [3:0] ALU_XOR = 4'd6;
  localparam logic [3:0] ALU_GE = 4'd7;
  localparam logic [3:0] ALU_LT = 4'd8;
  localparam logic [3:0] ALU_EQ = 4'd9;
  localparam logic [3:0] ALU_NE = 4'd10;
  localparam logic [3:0] ALU_SLL = 4'd11;
  localparam logic [3:0] ALU_SRL = 4'd12;
  localparam logic [3:0] ALU_SRA = 4'd13;
endpackage

// File: rtl/skid_buf.sv
// skid_buf: 2-entry valid/ready buffer with state-decoded in_ready and flush
module skid_buf
  import npc_pkg::*;
#(
  parameter int W = UOP_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  skid_state_t state, state_nxt;
  logic [W-1:0] skid;
  logic in_xfer, out_xfer;
  assign in_xfer = in_valid && in_ready && !flush;
  assign out_xfer = out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= ST_EMPTY;
    else state <= state_nxt;
  always_comb
    state_nxt = flush ? ST_EMPTY :
                state == ST_EMPTY ? (in_xfer ? ST_BUSY : ST_EMPTY) :
                state == ST_BUSY ? (in_xfer && !out_xfer ? ST_FULL :
                                    !in_xfer && out_xfer ? ST_EMPTY : ST_BUSY) :
                (out_xfer ? ST_BUSY : ST_FULL);
  always_comb begin
    out_valid = state != ST_EMPTY;
    in_ready = state != ST_FULL;
  end
  // FULL never accepts, so an input transfer lands in main unless main is held
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_data <= '0;
      skid <= '0;
    end else begin
      if (in_xfer && (!out_valid || out_xfer)) out_data <= in_data;
      else if (state == ST_FULL && out_xfer) out_data <= skid;
      if (in_xfer && out_valid && !out_xfer) skid <= in_data;
    end
endmodule

// File: rtl/exu_issue.sv
// exu_issue: ID->EX issue stage, operand A/B mux in front of a 2-entry skid buffer
module exu_issue
  import npc_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int RW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [1:0]      in_asel,
  input  logic [1:0]      in_bsel,
  input  logic [3:0]      in_op,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_op,
  output logic [RW-1:0]   out_rd,
  output logic            out_wen
);
  localparam int PW = uop_w(XLEN, RW);
  logic [XLEN-1:0] a, b;
  logic [PW-1:0] in_uop, out_uop;
  always_comb begin
    a = in_asel == ASEL_RS1 ? in_rs1 : in_asel == ASEL_PC ? in_pc : '0;
    b = in_bsel == BSEL_RS2 ? in_rs2 : in_bsel == BSEL_IMM ? in_imm :
        in_bsel == BSEL_FOUR ? XLEN'(4) : '0;
  end
  assign in_uop = {a, b, in_op, in_rd, in_wen && (in_rd != '0)};
  skid_buf #(.W(PW)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_uop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_uop)
  );
  assign {out_a, out_b, out_op, out_rd, out_wen} = out_uop;
endmodule
